ssd_result_writer: RTL and testbench

- AHB-Lite single-master write engine. Sits upstream of the seven-segment display AHB slave.
- Accepts 5-bit classifier results over a valid/ready stream and buffers them in a small FIFO.
- For each result it issues two word writes: the result to the data register, then 1 to the done-flag register.
- Correctly pipelines address and data phases and honours wait states and two-cycle ERROR responses.

---
 rtl/ssd_result_writer.sv | 163 ++++++++++++++++
 tb/tb_ssd_result_writer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_result_writer.sv
// AHB-Lite write engine: buffers 5-bit results and posts each as a data write plus a done-flag write.
// Define SSD_RESULT_DEDUP_EN to drop results equal to the last successfully written value.
module ssd_result_writer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] DATA_ADDR  = 32'hC000_0000,
    parameter logic [31:0] FLAG_ADDR  = 32'hC000_0004
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        res_valid_i,
    input  logic [4:0]  res_data_i,
    output logic        res_ready_o,
    output logic [31:0] ahb_haddr_o,
    output logic        ahb_hwrite_o,
    output logic [2:0]  ahb_hsize_o,
    output logic [2:0]  ahb_hburst_o,
    output logic [3:0]  ahb_hprot_o,
    output logic [1:0]  ahb_htrans_o,
    output logic        ahb_hmastlock_o,
    output logic [31:0] ahb_hwdata_o,
    input  logic        ahb_hready_i,
    input  logic        ahb_hresp_i,
    output logic        busy_o,
    output logic        err_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_AP_DATA, S_AP_FLAG, S_DP_FLAG} state_t;

    state_t        state_q, state_d;
    logic [4:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          fifo_full, fifo_empty, push, pop, load;
    logic [4:0]    head, cur_q;
    logic          err_q, err_set, flag_done;
    logic          dup_idle, dup_dp;

    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty  = (count_q == '0);
    assign push        = res_valid_i && !fifo_full;
    assign head        = fifo_mem[rd_ptr_q];
    assign res_ready_o = !fifo_full;
    assign busy_o      = (state_q != S_IDLE) || !fifo_empty;
    assign err_o       = err_q;

    assign ahb_hwrite_o    = (ahb_htrans_o == HTRANS_NONSEQ);
    assign ahb_hsize_o     = 3'b010;
    assign ahb_hburst_o    = 3'b000;
    assign ahb_hprot_o     = 4'b0001;
    assign ahb_hmastlock_o = 1'b0;

    // Any error response seen while a data phase is outstanding
    assign err_set   = ahb_hresp_i && ((state_q == S_AP_FLAG) || (state_q == S_DP_FLAG));
    assign flag_done = (state_q == S_DP_FLAG) && ahb_hready_i && !ahb_hresp_i;

`ifdef SSD_RESULT_DEDUP_EN
    logic [4:0] last_q;
    logic       last_vld_q;

    // While the flag write is in flight, cur_q becomes the last value if it completes this cycle
    assign dup_idle = last_vld_q && (head == last_q);
    assign dup_dp   = (head == cur_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (err_set) begin
            last_vld_q <= 1'b0;
        end else if (flag_done) begin
            last_q     <= cur_q;
            last_vld_q <= 1'b1;
        end
    end
`else
    assign dup_idle = 1'b0;
    assign dup_dp   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= res_data_i;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cur_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (load)    cur_q <= head;
            if (err_set) err_q <= 1'b1;
        end
    end

    // Next state and bus outputs; the flag data phase overlaps the next data address phase
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        load         = 1'b0;
        ahb_htrans_o = HTRANS_IDLE;
        ahb_haddr_o  = '0;
        ahb_hwdata_o = '0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (!dup_idle) begin
                        load    = 1'b1;
                        state_d = S_AP_DATA;
                    end
                end
            end
            S_AP_DATA: begin
                ahb_htrans_o = HTRANS_NONSEQ;
                ahb_haddr_o  = DATA_ADDR;
                if (ahb_hready_i) state_d = S_AP_FLAG;
            end
            S_AP_FLAG: begin
                ahb_hwdata_o = {27'b0, cur_q};
                if (!ahb_hresp_i) begin
                    ahb_htrans_o = HTRANS_NONSEQ;
                    ahb_haddr_o  = FLAG_ADDR;
                end
                if (ahb_hready_i) state_d = ahb_hresp_i ? S_IDLE : S_DP_FLAG;
            end
            S_DP_FLAG: begin
                ahb_hwdata_o = 32'h1;
                if (!ahb_hresp_i && !fifo_empty && !dup_dp) begin
                    ahb_htrans_o = HTRANS_NONSEQ;
                    ahb_haddr_o  = DATA_ADDR;
                end
                if (ahb_hready_i) begin
                    state_d = S_IDLE;
                    if (flag_done && !fifo_empty) begin
                        pop = 1'b1;
                        if (!dup_dp) begin
                            load    = 1'b1;
                            state_d = S_AP_FLAG;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ssd_result_writer.sv
// Scoreboard bench for ssd_result_writer: expected bus writes queued at result acceptance, checked at data-phase completion.
module tb_ssd_result_writer;

    localparam logic [31:0] DATA_ADDR = 32'hC000_0000;
    localparam logic [31:0] FLAG_ADDR = 32'hC000_0004;
    localparam logic [1:0]  NONSEQ    = 2'b10;
`ifdef SSD_RESULT_DEDUP_EN
    localparam bit DEDUP_MODEL = 1'b1;
`else
    localparam bit DEDUP_MODEL = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk, resetn, res_valid, res_ready, hready, hresp;
    logic [4:0]  res_data;
    logic [31:0] haddr, hwdata;
    logic        hwrite, hmastlock, busy, err;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;

    int  n_checks = 0;
    int  n_fail = 0;
    wr_t exp_q[$];
    bit  pend = 1'b0;
    logic [31:0] pend_addr = '0;
    bit  accepted = 1'b0;
    bit  expect_writes = 1'b1;
    bit  m_last_vld = 1'b0;
    logic [4:0] m_last = '0;
    int  wr_count = 0;
    int  err_drops = 0;

    ssd_result_writer dut (
        .clk(clk), .resetn(resetn),
        .res_valid_i(res_valid), .res_data_i(res_data), .res_ready_o(res_ready),
        .ahb_haddr_o(haddr), .ahb_hwrite_o(hwrite), .ahb_hsize_o(hsize),
        .ahb_hburst_o(hburst), .ahb_hprot_o(hprot), .ahb_htrans_o(htrans),
        .ahb_hmastlock_o(hmastlock), .ahb_hwdata_o(hwdata),
        .ahb_hready_i(hready), .ahb_hresp_i(hresp),
        .busy_o(busy), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock: observe the bus mid-cycle, update scoreboard, then step past the edge
    task automatic tick();
        wr_t e;
        @(negedge clk);
        accepted = 1'b0;
        if (!resetn) begin
            pend = 1'b0;
        end else begin
            if (res_valid && res_ready) begin
                accepted = 1'b1;
                if (expect_writes && !(DEDUP_MODEL && m_last_vld && res_data == m_last)) begin
                    e.addr = DATA_ADDR; e.data = {27'b0, res_data}; exp_q.push_back(e);
                    e.addr = FLAG_ADDR; e.data = 32'h1;             exp_q.push_back(e);
                    m_last = res_data;
                    m_last_vld = 1'b1;
                end
            end
            if (pend && hready) begin
                pend = 1'b0;
                if (hresp) begin
                    err_drops++;
                end else begin
                    wr_count++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected: got addr=%h data=%h, required no write", pend_addr, hwdata);
                    end else begin
                        e = exp_q.pop_front();
                        if ({pend_addr, hwdata} !== {e.addr, e.data}) begin
                            n_fail++;
                            $display("FAIL sb_write: got addr=%h data=%h, required addr=%h data=%h",
                                     pend_addr, hwdata, e.addr, e.data);
                        end
                    end
                end
            end
            if (htrans == NONSEQ && hready) begin
                pend = 1'b1;
                pend_addr = haddr;
                n_checks++;
                if ({hwrite, hsize, hburst, hprot, hmastlock} !== {1'b1, 3'b010, 3'b000, 4'b0001, 1'b0}) begin
                    n_fail++;
                    $display("FAIL addr_attr: got %b, required 1_010_000_0001_0",
                             {hwrite, hsize, hburst, hprot, hmastlock});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [4:0] d);
        res_valid = 1'b1;
        res_data  = d;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (exp_q.size() == 0 && !busy && !pend) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_flag_ap(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (htrans == NONSEQ && haddr == FLAG_ADDR) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; res_valid = 1'b0; res_data = '0; hready = 1'b1; hresp = 1'b0;
        #3;
        n_checks++;
        if ({res_ready, htrans, haddr, hwrite, hwdata, busy, err} !== {1'b1, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got ready=%b htrans=%b haddr=%h hwrite=%b hwdata=%h busy=%b err=%b, required 1 00 0 0 0 0 0",
                     res_ready, htrans, haddr, hwrite, hwdata, busy, err);
        end
        n_checks++;
        if ({hsize, hburst, hprot, hmastlock} !== {3'b010, 3'b000, 4'b0001, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_consts: got %b, required 010_000_0001_0", {hsize, hburst, hprot, hmastlock});
        end
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        push_one(5'h0B);
        n_checks++;
        if ({htrans, busy} !== {2'b00, 1'b1}) begin
            n_fail++;
            $display("FAIL single_no_bypass: got htrans=%b busy=%b, required 00 1", htrans, busy);
        end
        tick();
        n_checks++;
        if ({htrans, haddr} !== {NONSEQ, DATA_ADDR}) begin
            n_fail++;
            $display("FAIL single_data_ap: got htrans=%b haddr=%h, required 10 %h", htrans, haddr, DATA_ADDR);
        end
        tick();
        n_checks++;
        if ({htrans, haddr, hwdata} !== {NONSEQ, FLAG_ADDR, 32'h0000_000B}) begin
            n_fail++;
            $display("FAIL single_flag_ap: got htrans=%b haddr=%h hwdata=%h, required 10 %h 0000000b",
                     htrans, haddr, hwdata, FLAG_ADDR);
        end
        tick();
        n_checks++;
        if ({htrans, hwdata} !== {2'b00, 32'h1}) begin
            n_fail++;
            $display("FAIL single_flag_dp: got htrans=%b hwdata=%h, required 00 00000001", htrans, hwdata);
        end
        tick();
        n_checks++;
        if ({busy, htrans, hwdata} !== {1'b0, 2'b00, 32'h0}) begin
            n_fail++;
            $display("FAIL single_idle: got busy=%b htrans=%b hwdata=%h, required 0 00 0", busy, htrans, hwdata);
        end
        drain(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL single_drain: got %0d pending writes, required 0", exp_q.size());
        end
    endtask

    task automatic test_wait_states();
        bit ok;
        logic [65:0] snap;
        push_one(5'h15);
        wait_flag_ap(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_reach_flag: got timeout, required flag address phase");
        end
        hready = 1'b0;
        snap = {htrans, haddr, hwdata};
        for (int i = 0; i < 2; i++) begin
            if (i == 1) hready = 1'b1;
            n_checks++;
            if ({htrans, haddr, hwdata} !== {NONSEQ, FLAG_ADDR, 32'h15} || snap !== {NONSEQ, FLAG_ADDR, 32'h15}) begin
                n_fail++;
                $display("FAIL wait_hold: got htrans=%b haddr=%h hwdata=%h, required 10 %h 00000015",
                         htrans, haddr, hwdata, FLAG_ADDR);
            end
            if (i == 0) tick();
        end
        drain(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_drain: got %0d pending writes, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [1:0] seq [12];
        int first, run, total;
        push_one(5'h01); seq[0] = htrans;
        push_one(5'h02); seq[1] = htrans;
        push_one(5'h03); seq[2] = htrans;
        for (int i = 3; i < 12; i++) begin
            tick();
            seq[i] = htrans;
        end
        first = -1; run = 0; total = 0;
        for (int i = 0; i < 12; i++) begin
            if (seq[i] == NONSEQ) begin
                total++;
                if (first < 0) first = i;
                if (i == first + run) run++;
            end
        end
        n_checks++;
        if (run !== 6) begin
            n_fail++;
            $display("FAIL b2b_run: got %0d consecutive NONSEQ cycles, required 6", run);
        end
        n_checks++;
        if (total !== 6) begin
            n_fail++;
            $display("FAIL b2b_total: got %0d NONSEQ cycles, required 6", total);
        end
        drain(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_drain: got %0d pending writes, required 0", exp_q.size());
        end
    endtask

    task automatic test_fifo_full();
        bit ok;
        int k;
        logic [4:0] vals [6];
        for (int i = 0; i < 6; i++) vals[i] = 5'(5'h11 + i);
        hready = 1'b0;
        k = 0;
        for (int c = 0; c < 12 && k < 5; c++) begin
            res_valid = 1'b1;
            res_data  = vals[k];
            tick();
            if (accepted) k++;
        end
        n_checks++;
        if ({k[3:0], res_ready, busy} !== {4'd5, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL full_ready: got accepted=%0d ready=%b busy=%b, required 5 0 1", k, res_ready, busy);
        end
        res_data = vals[5];
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({accepted, res_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL full_hold: got accepted=%b ready=%b, required 0 0", accepted, res_ready);
            end
        end
        hready = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (accepted) begin
                ok = 1'b1;
                break;
            end
        end
        res_valid = 1'b0;
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL full_sixth: got not accepted, required accepted after release");
        end
        drain(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drain: got %0d pending writes, required 0", exp_q.size());
        end
    endtask

    task automatic test_error();
        bit ok;
        int drops0;
        drops0 = err_drops;
        expect_writes = 1'b0;
        push_one(5'h0A);
        expect_writes = 1'b1;
        wait_flag_ap(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL err_reach_flag: got timeout, required flag address phase");
        end
        hresp = 1'b1; hready = 1'b0;
        #1;
        n_checks++;
        if (htrans !== 2'b00) begin
            n_fail++;
            $display("FAIL err_cancel: got htrans=%b, required 00", htrans);
        end
        tick();
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_flag_set: got err=%b, required 1", err);
        end
        hready = 1'b1;
        n_checks++;
        if (htrans !== 2'b00) begin
            n_fail++;
            $display("FAIL err_second_cycle: got htrans=%b, required 00", htrans);
        end
        tick();
        hresp = 1'b0;
        n_checks++;
        if (err_drops !== drops0 + 1) begin
            n_fail++;
            $display("FAIL err_drop: got %0d errored transfers, required %0d", err_drops - drops0, 1);
        end
        m_last_vld = 1'b0;
        push_one(5'h1C);
        drain(ok);
        n_checks++;
        if ({ok, err} !== 2'b11) begin
            n_fail++;
            $display("FAIL err_recover: got drained=%b err=%b pending=%0d, required 1 1 0", ok, err, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int nonseq;
        push_one(5'h03);
        push_one(5'h04);
        push_one(5'h05);
        wait_flag_ap(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_reach_flag: got timeout, required flag address phase");
        end
        resetn = 1'b0;
        #1;
        exp_q.delete();
        m_last_vld = 1'b0;
        n_checks++;
        if ({htrans, res_ready, busy} !== {2'b00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_async: got htrans=%b ready=%b busy=%b, required 00 1 0", htrans, res_ready, busy);
        end
        tick();
        tick();
        resetn = 1'b1;
        nonseq = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (htrans == NONSEQ) nonseq++;
        end
        n_checks++;
        if ({nonseq, busy} !== {32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_quiet: got nonseq=%0d busy=%b, required 0 0", nonseq, busy);
        end
    endtask

    task automatic test_dedup();
        bit ok;
        int w0;
        w0 = wr_count;
        push_one(5'h07);
        push_one(5'h07);
        drain(ok);
        n_checks++;
        if ({ok, wr_count - w0} !== {1'b1, (DEDUP_MODEL ? 32'd2 : 32'd4)}) begin
            n_fail++;
            $display("FAIL dedup_writes: got drained=%b writes=%0d, required 1 %0d",
                     ok, wr_count - w0, DEDUP_MODEL ? 2 : 4);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wait_states();
        test_back_to_back();
        test_fifo_full();
        test_error();
        test_reset_mid();
        test_dedup();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
